interrupt_requester: RTL

Source-side counterpart of the LED interrupt decoder. It latches event pulses from three interrupt sources into a pending register and presents the highest-priority enabled pending source as a one-hot `sel` code, using a valid/ready handshake. On acknowledge it clears the serviced pending bit and enforces a programmable quiet gap before the next presentation. It sits between the event sources and the decoder that drives the indicator LEDs.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_priority_pick.sv | 16 +
 rtl/interrupt_requester.sv | 117 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt requester and the decoder side.
package irq_pkg;

  // Bit N_SRC-1 is the highest-priority source.
  localparam int unsigned N_SRC = 3;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } irq_state_t;

  // One-hot vector of the highest set bit of req; zero when req is zero.
  function automatic logic [N_SRC-1:0] prio_onehot(input logic [N_SRC-1:0] req);
    logic [N_SRC-1:0] res;
    res = '0;
    // Later (higher) bits overwrite earlier ones, leaving only the top set bit.
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (req[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_priority_pick.sv
// Combinational fixed-priority picker: one-hot of the highest requesting source.
module irq_priority_pick
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  output logic [N_SRC-1:0] sel_o,
  output logic             any_o
);

  // Priority selection and request-present flag.
  always_comb begin
    sel_o = prio_onehot(req_i);
    any_o = |req_i;
  end

endmodule

// File: rtl/interrupt_requester.sv
// Latches interrupt events into a pending vector and presents the highest-priority
// enabled source as a one-hot code over a valid/ready handshake, with a quiet gap
// after every acknowledge.
module interrupt_requester
  import irq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_evt,
  input  logic [N_SRC-1:0] mask,
  input  logic             irq_ready,
  output logic             irq_valid,
  output logic [N_SRC-1:0] sel,
  output logic [N_SRC-1:0] pending,
  output logic             overflow
);

  // $clog2(1) is 0, so a zero gap still gets a one-bit counter.
  localparam int unsigned CntW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  irq_state_t       state_q, state_d;
  logic [N_SRC-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] pick_sel;
  logic             pick_any;

  irq_priority_pick u_pick (
    .req_i (pend_q & mask),
    .sel_o (pick_sel),
    .any_o (pick_any)
  );

  // Pending and overflow bookkeeping; a new event on the bit being acked re-arms it.
  always_comb begin
    ack_clr = (valid_q && irq_ready) ? sel_q : '0;
    pend_d  = (pend_q & ~ack_clr) | src_evt;
    ovf_d   = ovf_q | (|(src_evt & pend_q & ~ack_clr));
  end

  // Presentation FSM: pick in IDLE, hold in PRESENT, count down the quiet gap in GAP.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_sel;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // sel is frozen here; mask and new events only matter at the next pick.
        if (irq_ready) begin
          sel_d   = '0;
          valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GapLoad;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt_q <= CntOne) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign irq_valid = valid_q;
  assign sel       = sel_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule
